uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLOCK_SPEED, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate.
REQ-003 The block SHALL have parameter CLOCKS_PER_BIT, default (CLOCK_SPEED / BAUD_RATE) + 1, meaning clk cycles per bit; 10417 at defaults.
REQ-004 The block SHALL have parameter GAP_BITS, default 4, meaning the maximum idle time between the two frames of a word, in bit periods.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-007 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-008 data  output  16  last received word: frame 0 in [7:0], frame 1 in [15:8].
REQ-009 data_valid  output  1  one-cycle pulse; data updated in the same cycle.
REQ-010 frame_err  output  1  one-cycle pulse on bad stop bit or inter-frame timeout.
REQ-011 busy  output  1  high while a frame is in progress or frame 1 is awaited.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (rxd_s); both flops reset to 1.
REQ-013 Frame format SHALL be 1 start (0), 8 data LSB-first, 1 stop (1); no parity; each word is two back-to-back frames.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP with a 14-bit bit counter, a 3-bit bit index, an 8-bit shift register and a byte_sel flag.
REQ-015 IDLE: falling edge of rxd_s (previous 1, current 0) -> START with counter 0; a line held low SHALL NOT retrigger.
REQ-016 START: at counter == CLOCKS_PER_BIT/2 - 1, if rxd_s == 0 -> DATA with counter 0; otherwise -> IDLE as a glitch, with no error pulse.
REQ-017 DATA: at counter == CLOCKS_PER_BIT - 1, the block SHALL shift rxd_s into bit [7] (LSB-first assembly) and increment the index; after the 8th bit -> STOP.
REQ-018 The counter SHALL wrap to 0 at every sample point, so sampling stays mid-bit.
REQ-019 STOP: at counter == CLOCKS_PER_BIT - 1, the block SHALL sample rxd_s and return to IDLE.
REQ-020 A stop bit of 1 with byte_sel == 0 SHALL store the byte as the low byte and set byte_sel.
REQ-021 A stop bit of 1 with byte_sel == 1 SHALL set data <= {byte, low byte}, pulse data_valid for 1 cycle and clear byte_sel.
REQ-022 A stop bit of 0 SHALL pulse frame_err, clear byte_sel, discard the partial word and leave data unchanged.
REQ-023 Inter-frame gap: while in IDLE with byte_sel == 1, a gap counter SHALL run; at GAP_BITS*CLOCKS_PER_BIT cycles without a start edge the block SHALL pulse frame_err and clear byte_sel; a start edge SHALL clear the gap counter.
REQ-024 Latency: data_valid SHALL assert 1 cycle after the frame-1 stop-bit sample point, i.e. about half a bit before the line stop-bit ends.
REQ-025 busy SHALL equal (state != IDLE) OR byte_sel.
REQ-026 data_valid and frame_err SHALL never assert in the same cycle.
REQ-027 data SHALL hold its value until the next valid word.

Reset
REQ-028 With rst == 0: state IDLE, counters 0, byte_sel 0, shift register 0, data 16'h0000, data_valid 0, frame_err 0, busy 0, synchronizer 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no pulses; after release, reception SHALL resume on the next falling edge.

Verification (CLOCK_SPEED=1_000_000, BAUD_RATE=100_000 -> CLOCKS_PER_BIT=11)
REQ-030 Two frames 8'hA5 then 8'h3C at 11 clk/bit, back-to-back -> one data_valid pulse, data=16'h3CA5, frame_err never high.
REQ-031 Low pulse of 3 clk on idle rxd -> returns to IDLE, busy low after the glitch, no pulses, data unchanged.
REQ-032 Frame 0 sent with stop bit 0 -> frame_err 1-cycle pulse, byte_sel 0; a following good pair 8'h01, 8'h02 -> data=16'h0201.
REQ-033 Frame 0 = 8'h55 then line idle for 50 clk -> frame_err pulse at 44 idle-gap cycles, busy low; a following pair 8'hFF, 8'h00 -> data=16'h00FF.
REQ-034 rst driven low during DATA bit 4 of frame 1 -> outputs at reset values asynchronously, no data_valid; a new pair 8'h12, 8'h34 -> data=16'h3412.
REQ-035 Two words sent with 0 idle bits between them -> two data_valid pulses, with data updated to each word in turn.

Source files
------------

// File: rtl/uart_rx.sv
// Two-frame UART receiver (8N1, LSB first) assembling a 16-bit word: frame 0 -> [7:0], frame 1 -> [15:8].
// Latency: data_valid/frame_err are registered, one clk after the frame-1 stop-bit mid-point sample.
// Backpressure: none; data_valid is a single-cycle strobe and data holds until the next good word.
module uart_rx #(
    parameter int CLOCK_SPEED    = 100_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int CLOCKS_PER_BIT = (CLOCK_SPEED / BAUD_RATE) + 1,
    parameter int GAP_BITS       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int              GAP_CYCLES = GAP_BITS * CLOCKS_PER_BIT;
    localparam int              GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam logic [13:0]     HALF_LAST  = 14'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [13:0]     BIT_LAST   = 14'(CLOCKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic             rxd_m, rxd_s, rxd_prev;
    logic [13:0]      cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shreg, sh_nxt;
    logic [7:0]       low_byte, low_nxt;
    logic             byte_sel, bs_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [15:0]      data_nxt;
    logic             dv_nxt, fe_nxt;
    logic             fall;

    // rxd_prev tracks the synchronized line so a line held low cannot retrigger.
    assign fall = rxd_prev & ~rxd_s;
    assign busy = (state != IDLE) | byte_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            rxd_prev   <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            low_byte   <= '0;
            byte_sel   <= 1'b0;
            gap_cnt    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxd_m      <= rxd;
            rxd_s      <= rxd_m;
            rxd_prev   <= rxd_s;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= idx_nxt;
            shreg      <= sh_nxt;
            low_byte   <= low_nxt;
            byte_sel   <= bs_nxt;
            gap_cnt    <= gap_nxt;
            data       <= data_nxt;
            data_valid <= dv_nxt;
            frame_err  <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = bit_idx;
        sh_nxt    = shreg;
        low_nxt   = low_byte;
        bs_nxt    = byte_sel;
        gap_nxt   = gap_cnt;
        data_nxt  = data;
        dv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (fall) begin
                    state_nxt = START;
                    gap_nxt   = '0;
                end else if (byte_sel) begin
                    // Frame 1 never arrived: drop the half word.
                    if (gap_cnt == GAP_LAST) begin
                        fe_nxt  = 1'b1;
                        bs_nxt  = 1'b0;
                        gap_nxt = '0;
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end else begin
                    gap_nxt = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 14'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rxd_s, shreg[7:1]};
                    idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 14'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rxd_s) begin
                        if (byte_sel) begin
                            data_nxt = {shreg, low_byte};
                            dv_nxt   = 1'b1;
                            bs_nxt   = 1'b0;
                        end else begin
                            low_nxt = shreg;
                            bs_nxt  = 1'b1;
                        end
                    end else begin
                        fe_nxt = 1'b1;
                        bs_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + 14'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 11;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic [15:0] data;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Free-running observers; tasks compare against snapshots of these totals.
    int          cyc = 0;
    int          dv_total = 0;
    int          fe_total = 0;
    int          both_total = 0;
    int          last_fe_cyc = 0;
    logic [15:0] dv_log [0:31];

    uart_rx #(
        .CLOCK_SPEED(1_000_000),
        .BAUD_RATE  (100_000),
        .GAP_BITS   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            if (dv_total < 32) dv_log[dv_total] <= data;
            dv_total <= dv_total + 1;
        end
        if (frame_err) begin
            fe_total    <= fe_total + 1;
            last_fe_cyc <= cyc;
        end
        if (data_valid && frame_err) both_total <= both_total + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rxd = 1'b1;
        wait_clk(3);
        checks++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_basic_word;
        int dv0, fe0;
        dv0 = dv_total; fe0 = fe_total;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_clk(10);
        checks++; if (dv_total - dv0 !== 1) begin errors++; $display("FAIL basic_dv_count got %0d want 1", dv_total - dv0); end
        checks++; if (dv_log[dv0] !== 16'h3CA5) begin errors++; $display("FAIL basic_pulse_data got %h want 3CA5", dv_log[dv0]); end
        checks++; if (data !== 16'h3CA5) begin errors++; $display("FAIL basic_data_hold got %h want 3CA5", data); end
        checks++; if (fe_total - fe0 !== 0) begin errors++; $display("FAIL basic_fe_count got %0d want 0", fe_total - fe0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
    endtask

    task automatic test_glitch;
        int dv0, fe0;
        dv0 = dv_total; fe0 = fe_total;
        rxd = 1'b0;
        wait_clk(3);
        rxd = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during got %b want 1", busy); end
        wait_clk(15);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after got %b want 0", busy); end
        checks++; if ((dv_total - dv0) + (fe_total - fe0) !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", (dv_total - dv0) + (fe_total - fe0)); end
        checks++; if (data !== 16'h3CA5) begin errors++; $display("FAIL glitch_data got %h want 3CA5", data); end
    endtask

    task automatic test_stop_error;
        int dv0, fe0;
        dv0 = dv_total; fe0 = fe_total;
        send_frame(8'h77, 1'b0);
        wait_clk(CPB);
        checks++; if (fe_total - fe0 !== 1) begin errors++; $display("FAIL stoperr_fe_count got %0d want 1", fe_total - fe0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stoperr_busy got %b want 0", busy); end
        checks++; if (data !== 16'h3CA5) begin errors++; $display("FAIL stoperr_data_kept got %h want 3CA5", data); end
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        wait_clk(10);
        checks++; if (dv_total - dv0 !== 1) begin errors++; $display("FAIL stoperr_dv_count got %0d want 1", dv_total - dv0); end
        checks++; if (data !== 16'h0201) begin errors++; $display("FAIL stoperr_next_word got %h want 0201", data); end
    endtask

    task automatic test_gap_timeout;
        int dv0, fe0, idle_start, offs;
        dv0 = dv_total; fe0 = fe_total;
        send_frame(8'h55, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy_waiting got %b want 1", busy); end
        idle_start = cyc;
        wait_clk(50);
        // Stop sample lands 3 clk before the stop bit ends, so the 44-cycle gap expires ~41 clk into idle.
        offs = last_fe_cyc - idle_start;
        checks++; if (fe_total - fe0 !== 1) begin errors++; $display("FAIL gap_fe_count got %0d want 1", fe_total - fe0); end
        checks++; if (offs < 39 || offs > 43) begin errors++; $display("FAIL gap_fe_time got %0d want 39..43", offs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_after got %b want 0", busy); end
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        wait_clk(10);
        checks++; if (dv_total - dv0 !== 1) begin errors++; $display("FAIL gap_dv_count got %0d want 1", dv_total - dv0); end
        checks++; if (data !== 16'h00FF) begin errors++; $display("FAIL gap_next_word got %h want 00FF", data); end
    endtask

    task automatic test_reset_mid_frame;
        int dv0;
        dv0 = dv_total;
        send_frame(8'hAB, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b0;
        wait_clk(4);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (data !== 16'h0000) begin errors++; $display("FAIL rstmid_data got %h want 0000", data); end
        checks++; if (data_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulses got %b%b want 00", data_valid, frame_err); end
        rxd = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(10);
        checks++; if (dv_total - dv0 !== 0) begin errors++; $display("FAIL rstmid_no_dv got %0d want 0", dv_total - dv0); end
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_clk(10);
        checks++; if (dv_total - dv0 !== 1) begin errors++; $display("FAIL rstmid_dv_count got %0d want 1", dv_total - dv0); end
        checks++; if (data !== 16'h3412) begin errors++; $display("FAIL rstmid_next_word got %h want 3412", data); end
    endtask

    task automatic test_back_to_back;
        int dv0, fe0;
        dv0 = dv_total; fe0 = fe_total;
        send_frame(8'hAA, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h0F, 1'b1);
        send_frame(8'hF0, 1'b1);
        wait_clk(10);
        checks++; if (dv_total - dv0 !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d want 2", dv_total - dv0); end
        checks++; if (dv_log[dv0] !== 16'h55AA) begin errors++; $display("FAIL b2b_word0 got %h want 55AA", dv_log[dv0]); end
        checks++; if (dv_log[dv0 + 1] !== 16'hF00F) begin errors++; $display("FAIL b2b_word1 got %h want F00F", dv_log[dv0 + 1]); end
        checks++; if (fe_total - fe0 !== 0) begin errors++; $display("FAIL b2b_fe_count got %0d want 0", fe_total - fe0); end
        checks++; if (both_total !== 0) begin errors++; $display("FAIL dv_fe_overlap got %0d want 0", both_total); end
    endtask

    initial begin
        rst = 1'b0;
        rxd = 1'b1;
        test_reset();
        test_basic_word();
        test_glitch();
        test_stop_error();
        test_gap_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
